alu_issue: RTL and testbench
============================

# alu_issue

Issue sequencer that drives the CPU's edge-triggered ALU. It accepts a decoded R-type instruction plus register operands over a valid/ready handshake. It presents stable operands to the ALU, fires a single-cycle `go` strobe, waits for the result to settle, and returns a register writeback over a second valid/ready handshake. It sits between the register-read stage and the register-file write port, and tracks HI/LO state for MFHI/MFLO.

## Interface
- `SETTLE_CYCLES`, default 1: cycles between the `go` high cycle and result capture; legal range 1–15.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE and not in reset.
- `instr` input 32: R-type word; rd=[15:11], shamt=[10:6], funct=[5:0].
- `rs_val` input 32: value of register rs.
- `rt_val` input 32: value of register rt.
- `a` output 32: ALU operand a, registered.
- `b` output 32: ALU operand b, registered.
- `shamt` output 5: ALU shift amount, registered.
- `funct` output 6: ALU function, registered.
- `go` output 1: ALU strobe, registered, high for exactly one cycle per op.
- `alu_out` input 32: ALU result.
- `alu_hi` input 32: ALU HI.
- `alu_lo` input 32: ALU LO.
- `wb_valid` output 1: writeback present.
- `wb_ready` input 1: register file accepts.
- `wb_rd` output 5: destination register.
- `wb_data` output 32: writeback value.
- `err_illegal` output 1: one-cycle pulse on an unsupported funct.
- `err_div0` output 1: one-cycle pulse on DIV with `rt_val`==0.
- `hilo_valid` output 1: HI/LO written since reset.

## Operation
- Supported functs: 00, 02, 03, 10, 12, 18, 1A, 20, 22, 24, 25, 26, 27, 2A.
- Operand mapping:
  - Shifts (00/02/03): `a`=`rt_val`, `b`=0, `shamt`=instr shamt. This gives MIPS semantics, because the ALU shifts `a`.
  - All other functs: `a`=`rs_val`, `b`=`rt_val`, `shamt`=0.
- Writing ops are every supported funct except 18 and 1A.
- States: IDLE → DRIVE → PULSE → WAIT → (WB | IDLE) → IDLE.
- IDLE: on `req_valid`&&`req_ready`, decode the request.
  - Illegal funct: pulse `err_illegal`, stay in IDLE, consume the request, no `go`.
  - Funct 1A with `rt_val`==0: pulse `err_div0`, stay in IDLE, consume the request, no `go`.
  - Otherwise: latch operands and `wb_rd`, go to DRIVE.
- DRIVE: operands stable, `go`=0. Next state PULSE.
- PULSE: `go`=1. Next state WAIT, with the counter loaded to `SETTLE_CYCLES`.
- WAIT: `go`=0; decrement the counter. At 0:
  - Writing op with rd≠0: capture `alu_out` into `wb_data`, go to WB.
  - Mult/div: set `hilo_valid`, go to IDLE.
  - rd==0: go to IDLE, no writeback.
- WB: hold `wb_valid`, `wb_rd` and `wb_data` stable until `wb_valid`&&`wb_ready`, then go to IDLE.
- MFHI/MFLO with `hilo_valid`=0 are still issued. The ALU's value is returned unchanged; no error is raised.
- Reset values: state IDLE, counter 0, all outputs 0 (`a`, `b`, `shamt`, `funct`, `go`, `wb_*`, `err_*`, `hilo_valid`). `req_ready`=0 while `reset` is high.
- Reset mid-operation aborts the op. No writeback, no `go` after the reset edge. The ALU's internal HI/LO are not cleared.

## Timing
- Accept at edge T.
- DRIVE during T+1.
- `go`=1 during T+2.
- WAIT during T+3 … T+2+`SETTLE_CYCLES`.
- `wb_valid` is first high at T+3+`SETTLE_CYCLES`; with the default this is T+4.
- `a`, `b`, `funct` and `shamt` are stable from T+1 until the next accept, so the rising edge of `go` always sees settled operands.
- `go` is never high two cycles in a row, and never high outside PULSE.
- Error pulses occur in the cycle after the accept edge. `req_ready` stays high, so back-to-back erroneous requests are accepted every cycle.
- Throughput:
  - Writing op: one op per 4+`SETTLE_CYCLES` cycles when `wb_ready` is held high.
  - Mult/div or rd==0: one op per 3+`SETTLE_CYCLES` cycles.

## Structure
- Shared package/include `alu_defs`, used by both the ALU and this block:
  - funct code constants (FN_SLL, FN_SRL, FN_SRA, FN_MFHI, FN_MFLO, FN_MULT, FN_DIV, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT);
  - the issue state encoding.
- One combinational sub-module, `alu_funct_decode`. Input is funct. Outputs are legal, is_shift, writes_rd and writes_hilo.
- The FSM, counter and registers live in `alu_issue`.

## Test plan
- ADD: `rs_val`=5, `rt_val`=7, rd=3, `wb_ready`=1 → `go` high exactly at T+2; `wb_valid` at T+4 with `wb_rd`=3, `wb_data`=12; `req_ready` high again at T+5.
- SLL: `rt_val`=1, shamt=4, `rs_val`=0xFFFF → ALU sees `a`=1; `wb_data`=16.
- MULT 0x10000×0x10000, then MFHI rd=2 → no `wb_valid` for the MULT; `hilo_valid`=1; MFHI returns `wb_data`=1.
- DIV with `rt_val`=0 → `err_div0` for one cycle; `go` never asserts; `hilo_valid` unchanged. Funct 0x3F → `err_illegal` for one cycle; `go` never asserts.
- Backpressure: `wb_ready`=0 for 5 cycles → `wb_*` held constant; `req_ready`=0 throughout; a single handshake completes on release. With rd=0, no `wb_valid` at all.
- `reset` asserted during PULSE → `go`=0 and state IDLE the cycle after; no `wb_valid`; all outputs 0. With `SETTLE_CYCLES`=3, `wb_valid` appears at T+6.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: funct codes, widths and the issue-sequencer state encoding.
package alu_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_MFHI = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MFLO = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MULT = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_DIV  = 6'h1A;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } issue_state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Classifies an R-type funct code: legality, shift operand routing and result destination.
module alu_funct_decode
  import alu_defs::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  output logic               legal_o,
  output logic               is_shift_o,
  output logic               writes_rd_o,
  output logic               writes_hilo_o
);

  always_comb begin
    legal_o       = 1'b0;
    is_shift_o    = 1'b0;
    writes_rd_o   = 1'b0;
    writes_hilo_o = 1'b0;
    case (funct_i)
      FN_SLL, FN_SRL, FN_SRA: begin
        legal_o     = 1'b1;
        is_shift_o  = 1'b1;
        writes_rd_o = 1'b1;
      end
      FN_MFHI, FN_MFLO, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
        legal_o     = 1'b1;
        writes_rd_o = 1'b1;
      end
      FN_MULT, FN_DIV: begin
        legal_o       = 1'b1;
        writes_hilo_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue sequencer for the edge-triggered ALU: latch operands, strobe go once,
// wait for the result to settle, then hand the writeback to the register file.
module alu_issue
  import alu_defs::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [XLEN-1:0]     instr,
  input  logic [XLEN-1:0]     rs_val,
  input  logic [XLEN-1:0]     rt_val,
  output logic [XLEN-1:0]     a,
  output logic [XLEN-1:0]     b,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic                go,
  input  logic [XLEN-1:0]     alu_out,
  input  logic [XLEN-1:0]     alu_hi,
  input  logic [XLEN-1:0]     alu_lo,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                err_illegal,
  output logic                err_div0,
  output logic                hilo_valid
);

  issue_state_e         state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [XLEN-1:0]      a_q, b_q, wb_data_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [FUNCT_W-1:0]   funct_q;
  logic [REG_W-1:0]     wb_rd_q;
  logic                 go_q, wb_valid_q, err_ill_q, err_div0_q, hilo_valid_q;
  logic                 op_writes_rd_q, op_writes_hilo_q;

  logic [FUNCT_W-1:0]   req_funct;
  logic [REG_W-1:0]     req_rd;
  logic [SHAMT_W-1:0]   req_shamt;
  logic                 dec_legal, dec_shift, dec_writes_rd, dec_writes_hilo;
  logic                 req_div0;

  // HI/LO reach the register file through alu_out (MFHI/MFLO), so these are not consumed here.
  logic unused_ok;
  assign unused_ok = ^{instr[31:16], alu_hi, alu_lo};

  assign req_funct = instr[5:0];
  assign req_shamt = instr[10:6];
  assign req_rd    = instr[15:11];
  assign req_div0  = (req_funct == FN_DIV) && (rt_val == '0);

  alu_funct_decode u_decode (
    .funct_i       (req_funct),
    .legal_o       (dec_legal),
    .is_shift_o    (dec_shift),
    .writes_rd_o   (dec_writes_rd),
    .writes_hilo_o (dec_writes_hilo)
  );

  assign req_ready = (state_q == ST_IDLE) && !reset;

  // Sequencer: error pulses and go are single-cycle, everything else holds until changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      a_q              <= '0;
      b_q              <= '0;
      shamt_q          <= '0;
      funct_q          <= '0;
      go_q             <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      err_ill_q        <= 1'b0;
      err_div0_q       <= 1'b0;
      hilo_valid_q     <= 1'b0;
      op_writes_rd_q   <= 1'b0;
      op_writes_hilo_q <= 1'b0;
    end else begin
      go_q       <= 1'b0;
      err_ill_q  <= 1'b0;
      err_div0_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (!dec_legal) begin
              err_ill_q <= 1'b1;
            end else if (req_div0) begin
              err_div0_q <= 1'b1;
            end else begin
              // Shifts act on a, so rt is routed there to get MIPS semantics.
              a_q              <= dec_shift ? rt_val : rs_val;
              b_q              <= dec_shift ? '0 : rt_val;
              shamt_q          <= dec_shift ? req_shamt : '0;
              funct_q          <= req_funct;
              wb_rd_q          <= req_rd;
              op_writes_rd_q   <= dec_writes_rd;
              op_writes_hilo_q <= dec_writes_hilo;
              state_q          <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          go_q    <= 1'b1;
          state_q <= ST_PULSE;
        end
        ST_PULSE: begin
          cnt_q   <= CNT_W'(SETTLE_CYCLES);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (op_writes_rd_q && (wb_rd_q != '0)) begin
              wb_data_q  <= alu_out;
              wb_valid_q <= 1'b1;
              state_q    <= ST_WB;
            end else begin
              if (op_writes_hilo_q) hilo_valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign shamt       = shamt_q;
  assign funct       = funct_q;
  assign go          = go_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign err_illegal = err_ill_q;
  assign err_div0    = err_div0_q;
  assign hilo_valid  = hilo_valid_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: vector table of single ops plus hand sequences for
// backpressure, back-to-back errors, reset mid-op and a longer settle time.
module tb_alu_issue;

  localparam int K_WB   = 0;
  localparam int K_NOWB = 1;
  localparam int K_ERR  = 2;
  localparam int NVEC   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_valid3, req_ready3;
  logic [31:0] instr, rs_val, rt_val;
  logic [31:0] a, b, alu_out, alu_hi, alu_lo, wb_data;
  logic [4:0]  shamt, wb_rd;
  logic [5:0]  funct;
  logic        go, wb_valid, wb_ready, err_illegal, err_div0, hilo_valid;
  logic [31:0] a3, b3, alu_out3, wb_data3;
  logic [4:0]  shamt3, wb_rd3;
  logic [5:0]  funct3;
  logic        go3, wb_valid3, err_illegal3, err_div03, hilo_valid3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .a(a), .b(b), .shamt(shamt), .funct(funct), .go(go),
    .alu_out(alu_out), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_illegal(err_illegal), .err_div0(err_div0), .hilo_valid(hilo_valid)
  );

  alu_issue #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .a(a3), .b(b3), .shamt(shamt3), .funct(funct3), .go(go3),
    .alu_out(alu_out3), .alu_hi(32'h0), .alu_lo(32'h0),
    .wb_valid(wb_valid3), .wb_ready(wb_ready), .wb_rd(wb_rd3), .wb_data(wb_data3),
    .err_illegal(err_illegal3), .err_div0(err_div03), .hilo_valid(hilo_valid3)
  );

  // Behavioural edge-triggered ALU; HI/LO persist across the sequencer's reset.
  logic [31:0] hi_r = 32'h0;
  logic [31:0] lo_r = 32'h0;
  assign alu_hi = hi_r;
  assign alu_lo = lo_r;
  initial alu_out = 32'h0;
  initial alu_out3 = 32'h0;

  always @(posedge clk) begin
    if (go) begin
      case (funct)
        6'h00: alu_out <= a << shamt;
        6'h02: alu_out <= a >> shamt;
        6'h03: alu_out <= 32'($signed(a) >>> shamt);
        6'h10: alu_out <= hi_r;
        6'h12: alu_out <= lo_r;
        6'h18: {hi_r, lo_r} <= {32'h0, a} * {32'h0, b};
        6'h1A: if (b != 32'h0) begin lo_r <= a / b; hi_r <= a % b; end
        6'h20: alu_out <= a + b;
        6'h22: alu_out <= a - b;
        6'h24: alu_out <= a & b;
        6'h25: alu_out <= a | b;
        6'h26: alu_out <= a ^ b;
        6'h27: alu_out <= ~(a | b);
        6'h2A: alu_out <= ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (go3) alu_out3 <= a3 + b3;

  typedef struct {
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    int          kind;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0]  esh;
    logic [31:0] edata;
    logic        eill;
    logic        ediv;
    logic        ehilo;
  } vec_t;

  vec_t vt [NVEC];

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {16'h0, rd, sh, fn};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Waits (bounded) for req_ready, presents one request, returns at the negedge after the accept edge.
  task automatic accept(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, output bit ok);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    ok = req_ready;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready stuck at %0b, required 1", req_ready);
    end else begin
      req_valid = 1'b1; instr = ins; rs_val = rs; rt_val = rt;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Issues one op and records what the DUT did over the 10 cycles after the accept edge.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        output int go_k, output int go_n, output int wb_k, output int rdy_k,
                        output int ill_n, output int div_n, output logic [31:0] ga,
                        output logic [31:0] gb, output logic [4:0] gsh, output logic [5:0] gfn,
                        output logic [31:0] wdat, output logic [4:0] wrd);
    bit ok;
    go_k = 0; go_n = 0; wb_k = 0; rdy_k = 0; ill_n = 0; div_n = 0;
    ga = '0; gb = '0; gsh = '0; gfn = '0; wdat = '0; wrd = '0;
    accept(ins, rs, rt, ok);
    if (ok) begin
      for (int k = 1; k <= 10; k++) begin
        if (k > 1) @(negedge clk);
        if (go) begin
          go_n++;
          if (go_k == 0) begin go_k = k; ga = a; gb = b; gsh = shamt; gfn = funct; end
        end
        if (wb_valid && wb_k == 0) begin wb_k = k; wdat = wb_data; wrd = wb_rd; end
        if (err_illegal) ill_n++;
        if (err_div0) div_n++;
        if (req_ready && rdy_k == 0) rdy_k = k;
      end
    end
  endtask

  initial begin
    int go_k, go_n, wb_k, rdy_k, ill_n, div_n, cnt, bad, hs;
    logic [31:0] ga, gb, wdat;
    logic [4:0]  gsh, wrd;
    logic [5:0]  gfn;
    bit          ok;
    string       p;

    //         fn     rd  sh  rs            rt            kind    ea            eb            esh  edata         ill   div   hilo
    vt[0]  = '{6'h12, 5'd6,  5'd0, 32'hAA,       32'hBB,       K_WB,   32'hAA,       32'hBB,       5'd0, 32'h0,        1'b0, 1'b0, 1'b0};
    vt[1]  = '{6'h20, 5'd3,  5'd0, 32'd5,        32'd7,        K_WB,   32'd5,        32'd7,        5'd0, 32'd12,       1'b0, 1'b0, 1'b0};
    vt[2]  = '{6'h00, 5'd4,  5'd4, 32'hFFFF,     32'd1,        K_WB,   32'd1,        32'd0,        5'd4, 32'd16,       1'b0, 1'b0, 1'b0};
    vt[3]  = '{6'h18, 5'd7,  5'd0, 32'h10000,    32'h10000,    K_NOWB, 32'h10000,    32'h10000,    5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[4]  = '{6'h10, 5'd2,  5'd0, 32'h0,        32'h0,        K_WB,   32'h0,        32'h0,        5'd0, 32'd1,        1'b0, 1'b0, 1'b1};
    vt[5]  = '{6'h12, 5'd5,  5'd0, 32'h0,        32'h0,        K_WB,   32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[6]  = '{6'h1A, 5'd0,  5'd0, 32'd7,        32'd0,        K_ERR,  32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 1'b1, 1'b1};
    vt[7]  = '{6'h3F, 5'd3,  5'd0, 32'd1,        32'd2,        K_ERR,  32'h0,        32'h0,        5'd0, 32'h0,        1'b1, 1'b0, 1'b1};
    vt[8]  = '{6'h22, 5'd7,  5'd0, 32'd3,        32'd5,        K_WB,   32'd3,        32'd5,        5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{6'h2A, 5'd8,  5'd0, 32'hFFFFFFFF, 32'd1,        K_WB,   32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        1'b0, 1'b0, 1'b1};
    vt[10] = '{6'h03, 5'd9,  5'd4, 32'h1234,     32'h80000000, K_WB,   32'h80000000, 32'h0,        5'd4, 32'hF8000000, 1'b0, 1'b0, 1'b1};
    vt[11] = '{6'h20, 5'd0,  5'd0, 32'd1,        32'd1,        K_NOWB, 32'd1,        32'd1,        5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[12] = '{6'h1A, 5'd0,  5'd0, 32'd17,       32'd5,        K_NOWB, 32'd17,       32'd5,        5'd0, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[13] = '{6'h12, 5'd1,  5'd0, 32'h0,        32'h0,        K_WB,   32'h0,        32'h0,        5'd0, 32'd3,        1'b0, 1'b0, 1'b1};
    vt[14] = '{6'h10, 5'd1,  5'd0, 32'h0,        32'h0,        K_WB,   32'h0,        32'h0,        5'd0, 32'd2,        1'b0, 1'b0, 1'b1};
    vt[15] = '{6'h27, 5'd10, 5'd0, 32'h0,        32'h0F,       K_WB,   32'h0,        32'h0F,       5'd0, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; wb_ready = 1'b1;
    instr = '0; rs_val = '0; rt_val = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ctrl_outs", 32'({go, wb_valid, err_illegal, err_div0, hilo_valid, shamt, funct, wb_rd}), 32'h0);
    chk("rst_a_b_data", a | b | wb_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(req_ready), 32'h1);

    // Table-driven single operations with wb_ready held high
    for (int i = 0; i < NVEC; i++) begin
      run_op(mk(vt[i].rd, vt[i].sh, vt[i].fn), vt[i].rs, vt[i].rt,
             go_k, go_n, wb_k, rdy_k, ill_n, div_n, ga, gb, gsh, gfn, wdat, wrd);
      p = $sformatf("v%0d_fn%02h", i, vt[i].fn);
      chk({p, "_go_count"}, 32'(go_n), (vt[i].kind != K_ERR) ? 32'd1 : 32'd0);
      chk({p, "_go_cycle"}, 32'(go_k), (vt[i].kind != K_ERR) ? 32'd2 : 32'd0);
      chk({p, "_wb_cycle"}, 32'(wb_k), (vt[i].kind == K_WB) ? 32'd4 : 32'd0);
      chk({p, "_ready_cycle"}, 32'(rdy_k),
          (vt[i].kind == K_ERR) ? 32'd1 : ((vt[i].kind == K_WB) ? 32'd5 : 32'd4));
      chk({p, "_err_illegal"}, 32'(ill_n), 32'(vt[i].eill));
      chk({p, "_err_div0"}, 32'(div_n), 32'(vt[i].ediv));
      chk({p, "_hilo_valid"}, 32'(hilo_valid), 32'(vt[i].ehilo));
      if (vt[i].kind != K_ERR) begin
        chk({p, "_a"}, ga, vt[i].ea);
        chk({p, "_b"}, gb, vt[i].eb);
        chk({p, "_shamt"}, 32'(gsh), 32'(vt[i].esh));
        chk({p, "_funct"}, 32'(gfn), 32'(vt[i].fn));
      end
      if (vt[i].kind == K_WB) begin
        chk({p, "_wb_data"}, wdat, vt[i].edata);
        chk({p, "_wb_rd"}, 32'(wrd), 32'(vt[i].rd));
      end
    end

    // Back-to-back illegal requests are consumed one per cycle
    @(negedge clk);
    cnt = 0; bad = 0;
    req_valid = 1'b1; instr = mk(5'd1, 5'd0, 6'h3F);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (err_illegal) cnt++;
      if (go) bad++;
      if (k == 3) req_valid = 1'b0;
    end
    chk("b2b_illegal_pulses", 32'(cnt), 32'd3);
    chk("b2b_illegal_go", 32'(bad), 32'd0);

    // Writeback backpressure: five stalled cycles, then a single handshake
    wb_ready = 1'b0;
    accept(mk(5'd11, 5'd0, 6'h20), 32'd2, 32'd3, ok);
    bad = 0; hs = 0; wb_k = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      if (wb_valid && wb_k == 0) wb_k = k;
      if (k >= 4 && k <= 8) begin
        if (!wb_valid || wb_rd != 5'd11 || wb_data != 32'd5 || req_ready) bad++;
      end
      if (k == 8) wb_ready = 1'b1;
      if (wb_valid && wb_ready) hs++;
      if (k == 9) begin
        chk("bp_release_wb_valid", 32'(wb_valid), 32'h0);
        chk("bp_release_ready", 32'(req_ready), 32'h1);
      end
    end
    chk("bp_wb_cycle", 32'(wb_k), 32'd4);
    chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
    chk("bp_handshakes", 32'(hs), 32'd1);

    // rd==0 never raises wb_valid, even with the register file stalled
    wb_ready = 1'b0;
    run_op(mk(5'd0, 5'd0, 6'h25), 32'd6, 32'd9,
           go_k, go_n, wb_k, rdy_k, ill_n, div_n, ga, gb, gsh, gfn, wdat, wrd);
    chk("rd0_stall_wb_cycle", 32'(wb_k), 32'd0);
    chk("rd0_stall_ready_cycle", 32'(rdy_k), 32'd4);
    wb_ready = 1'b1;

    // SETTLE_CYCLES=3 instance: go at T+2, writeback at T+6
    @(negedge clk);
    chk("s3_ready", 32'(req_ready3), 32'h1);
    req_valid3 = 1'b1; instr = mk(5'd3, 5'd0, 6'h20); rs_val = 32'd20; rt_val = 32'd22;
    @(negedge clk);
    req_valid3 = 1'b0;
    go_k = 0; wb_k = 0; wdat = '0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      if (go3 && go_k == 0) go_k = k;
      if (wb_valid3 && wb_k == 0) begin wb_k = k; wdat = wb_data3; end
    end
    chk("s3_go_cycle", 32'(go_k), 32'd2);
    chk("s3_wb_cycle", 32'(wb_k), 32'd6);
    chk("s3_wb_data", wdat, 32'd42);

    // Reset while go is high aborts the op
    accept(mk(5'd12, 5'd0, 6'h20), 32'd1, 32'd1, ok);
    @(negedge clk);
    chk("rstmid_go_before", 32'(go), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_ctrl_outs", 32'({go, wb_valid, err_illegal, err_div0, hilo_valid, req_ready, shamt, funct, wb_rd}), 32'h0);
    chk("rstmid_a_b_data", a | b | wb_data, 32'h0);
    reset = 1'b0;
    cnt = 0; rdy_k = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (go || wb_valid) cnt++;
      if (k == 1) rdy_k = 32'(req_ready);
    end
    chk("rstmid_idle_after", 32'(rdy_k), 32'h1);
    chk("rstmid_no_go_no_wb", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
